uart_rx_deserializer: RTL and testbench



---
 rtl/uart_rx_deserializer.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Receive front end of the AHB UART. Synchronises RX, finds the start bit on
// a 16x (OVERSAMPLE) baud tick, shifts in DATA_WIDTH data bits LSB first plus
// one parity bit, checks the stop bit, and hands {parity, data} downstream
// with a one-cycle rx_done strobe and a coincident framing-error strobe.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  baud_tick,
  input  logic                  RX,
  output logic [DATA_WIDTH:0]   data_in_parity,
  output logic                  rx_done,
  output logic                  FRAMEERR,
  output logic                  rx_busy
);

  localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  // Tick indices at which the line is sampled: mid start bit, end of each
  // full bit period (which lands mid-bit because START consumed half a bit).
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_meta_d;
  logic                    rx_s_q, rx_s_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic [DATA_WIDTH:0]     dip_q, dip_d;
  logic                    rx_done_q, rx_done_d;
  logic                    frameerr_q, frameerr_d;

  logic                    half_hit;
  logic                    full_hit;
  logic [DATA_WIDTH:0]     shift_ext;

  // Two-flop synchroniser inputs for the asynchronous RX line.
  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
  end

  // Next-state, counters, shift register and registered output strobes.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    dip_d      = dip_q;
    rx_done_d  = 1'b0;
    frameerr_d = 1'b0;

    half_hit  = baud_tick && (tick_cnt_q == HALF_LAST);
    full_hit  = baud_tick && (tick_cnt_q == FULL_LAST);
    // Right shift with the new bit entering at the MSB, so the first bit
    // received ends up at bit 0 after DATA_WIDTH shifts.
    shift_ext = {rx_s_q, shift_q};

    // Timed states count ticks; IDLE and WAIT_HIGH keep the counter at zero.
    if (baud_tick && (state_q != IDLE) && (state_q != WAIT_HIGH)) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (half_hit) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_hit) begin
          shift_d    = shift_ext[DATA_WIDTH:1];
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          tick_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (full_hit) begin
          parity_d = rx_s_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (full_hit) begin
          dip_d      = {parity_q, shift_q};
          rx_done_d  = 1'b1;
          frameerr_d = !rx_s_q;
          // A low stop bit may be a break; wait for the line to recover so a
          // held-low line does not look like a stream of start bits.
          state_d    = rx_s_q ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state change restarts the bit-timing count.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      dip_q      <= '0;
      rx_done_q  <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      dip_q      <= dip_d;
      rx_done_q  <= rx_done_d;
      frameerr_q <= frameerr_d;
    end
  end

  assign data_in_parity = dip_q;
  assign rx_done        = rx_done_q;
  assign FRAMEERR       = frameerr_q;
  assign rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: drives serial frames bit by bit on a
// free-running baud tick and compares every rx_done/FRAMEERR event (value and
// arrival tick) against a frame-level reference built from the sent bits.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int LATENCY  = OS / 2 + OS * (DW + 2);

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          baud_tick = 1'b0;
  logic          RX = 1'b1;
  logic [DW:0]   data_in_parity;
  logic          rx_done;
  logic          FRAMEERR;
  logic          rx_busy;

  int n_checks = 0;
  int n_errors = 0;
  int tick_no  = 0;

  typedef struct packed {
    logic        done;
    logic        fe;
    logic [DW:0] dip;
    logic [31:0] tick;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .baud_tick     (baud_tick),
    .RX            (RX),
    .data_in_parity(data_in_parity),
    .rx_done       (rx_done),
    .FRAMEERR      (FRAMEERR),
    .rx_busy       (rx_busy)
  );

  always #5 HCLK = ~HCLK;

  // Baud tick: one HCLK pulse every TICK_DIV clocks; tick_no is the index of
  // the tick currently high (advances when the pulse drops).
  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge HCLK);
      baud_tick = 1'b1;
      @(negedge HCLK);
      baud_tick = 1'b0;
      tick_no++;
    end
  end

  // Record every output strobe together with the tick that produced it.
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      if (rx_done || FRAMEERR) begin
        ev_t e;
        e.done = rx_done;
        e.fe   = FRAMEERR;
        e.dip  = data_in_parity;
        e.tick = tick_no;
        obs_q.push_back(e);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge baud_tick);
  endtask

  task automatic idle_ticks(input int n);
    RX = 1'b1;
    ticks(n);
  endtask

  // Send one complete frame starting at the current tick boundary and queue
  // the event the receiver must produce for it.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    ev_t e;
    RX     = 1'b0;
    e.done = 1'b1;
    e.fe   = !s;
    e.dip  = {p, d};
    e.tick = tick_no + LATENCY;
    exp_q.push_back(e);
    ticks(OS);
    for (int i = 0; i < DW; i++) begin
      RX = d[i];
      ticks(OS);
    end
    RX = p;
    ticks(OS);
    RX = s;
    ticks(OS);
  endtask

  task automatic check_events(input string tag);
    ev_t o;
    ev_t e;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_done"}, 32'(o.done), 32'(e.done));
      check_val({tag, "_fe"},   32'(o.fe),   32'(e.fe));
      check_val({tag, "_dip"},  32'(o.dip),  32'(e.dip));
      check_val({tag, "_tick"}, o.tick,      e.tick);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rp;
    logic [DW-1:0] abort_d;

    // Reset state.
    #22;
    check_val("rst_dip",  32'(data_in_parity), 32'h0);
    check_val("rst_done", 32'(rx_done), 32'h0);
    check_val("rst_fe",   32'(FRAMEERR), 32'h0);
    check_val("rst_busy", 32'(rx_busy), 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge baud_tick);
    idle_ticks(2 * OS);

    // 0x55, parity 0, good stop.
    send_frame(8'h55, 1'b0, 1'b1);
    check_val("f55_dip",  32'(data_in_parity), 32'h055);
    check_val("f55_busy", 32'(rx_busy), 32'h0);
    check_events("f55");
    idle_ticks(OS);

    // 0xA3, parity 1: first bit sent (1) must be bit 0.
    send_frame(8'hA3, 1'b1, 1'b1);
    check_val("fa3_bit0", 32'(data_in_parity[0]), 32'h1);
    check_events("fa3");
    idle_ticks(OS);

    // Start-bit glitch: low 4 ticks, then high.
    RX = 1'b0;
    ticks(2);
    check_val("glitch_busy_hi", 32'(rx_busy), 32'h1);
    ticks(2);
    RX = 1'b1;
    ticks(OS / 2 - 4 + 1);
    check_val("glitch_busy_lo", 32'(rx_busy), 32'h0);
    idle_ticks(2 * OS);
    check_val("glitch_hold_dip", 32'(data_in_parity), 32'h1A3);
    check_events("glitch");

    // Framing error: bad stop bit, line then held low for 40 ticks.
    send_frame(8'h0F, 1'b1, 1'b0);
    ticks(40);
    check_val("ferr_busy_low_line", 32'(rx_busy), 32'h1);
    idle_ticks(2 * OS);
    check_val("ferr_busy_after", 32'(rx_busy), 32'h0);
    check_events("ferr");

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    if (obs_q.size() >= 2) begin
      check_val("b2b_spacing", obs_q[1].tick - obs_q[0].tick, 32'd176);
    end
    check_events("b2b");
    idle_ticks(OS);

    // Reset during data bit 4.
    abort_d = 8'hD2;
    RX = 1'b0;
    ticks(OS);
    for (int i = 0; i < 4; i++) begin
      RX = abort_d[i];
      ticks(OS);
    end
    RX = abort_d[4];
    ticks(OS / 2);
    #3;
    HRESET = 1'b1;
    #1;
    check_val("midrst_dip",  32'(data_in_parity), 32'h0);
    check_val("midrst_done", 32'(rx_done), 32'h0);
    check_val("midrst_fe",   32'(FRAMEERR), 32'h0);
    check_val("midrst_busy", 32'(rx_busy), 32'h0);
    RX = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge baud_tick);
    idle_ticks(3 * OS);
    check_events("midrst");
    send_frame(8'h3C, 1'b0, 1'b1);
    check_events("f3c");
    idle_ticks(OS);

    // Randomised frames with random idle gaps (including none).
    for (int n = 0; n < 8; n++) begin
      rd = DW'($urandom_range(0, (1 << DW) - 1));
      rp = 1'($urandom_range(0, 1));
      send_frame(rd, rp, 1'b1);
      idle_ticks($urandom_range(0, 2 * OS));
    end
    check_events("rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
